// File: rtl/button_debouncer_multi.sv
// N-channel button debouncer: synchroniser, tick-based debounce, edge pulses,
// long-press detection and auto-repeat, one independent lane per channel.
module button_debouncer_multi #(
    parameter int NUM_CH       = 4,
    parameter int STABLE_COUNT = 5,
    parameter int LONG_COUNT   = 1000,
    parameter int REPEAT_COUNT = 200,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1khz,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_long,
    output logic [NUM_CH-1:0] btn_repeat,
    output logic [NUM_CH-1:0] btn_held,
    output logic              any_rise
);

    localparam int STAB_W = $clog2(STABLE_COUNT + 1);
    localparam int HOLD_W = $clog2(LONG_COUNT + 1);
    localparam int REP_W  = $clog2(REPEAT_COUNT + 1);

    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_COUNT - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_COUNT - 1);
    localparam logic [NUM_CH-1:0] INV_MASK  = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] rise_s;
    logic              any_rise_r;

    // Synchroniser chain; holds the logical (post-inversion) value so reset means released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= btn_in ^ INV_MASK;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [STAB_W-1:0] stab_cnt_r, stab_cnt_nxt_s;
        logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
        logic [REP_W-1:0]  rep_cnt_r, rep_cnt_nxt_s;
        logic state_r, state_nxt_s;
        logic held_r, held_nxt_s;
        logic rise_r, rise_nxt_s;
        logic fall_r, fall_nxt_s;
        logic long_r, long_nxt_s;
        logic repeat_r, repeat_nxt_s;

        // Debounce, hold and repeat next-state; an accepted fall overrides long/repeat.
        always_comb begin
            stab_cnt_nxt_s = stab_cnt_r;
            hold_cnt_nxt_s = hold_cnt_r;
            rep_cnt_nxt_s  = rep_cnt_r;
            state_nxt_s    = state_r;
            held_nxt_s     = held_r;
            rise_nxt_s     = 1'b0;
            fall_nxt_s     = 1'b0;
            long_nxt_s     = 1'b0;
            repeat_nxt_s   = 1'b0;
            if (tick_1khz) begin
                if (sync_s[g] == state_r) begin
                    stab_cnt_nxt_s = '0;
                end else if (stab_cnt_r < STAB_MAX) begin
                    stab_cnt_nxt_s = stab_cnt_r + STAB_W'(1);
                end else begin
                    stab_cnt_nxt_s = '0;
                    state_nxt_s    = sync_s[g];
                    rise_nxt_s     = sync_s[g];
                    fall_nxt_s     = ~sync_s[g];
                end

                if (fall_nxt_s) begin
                    hold_cnt_nxt_s = '0;
                    rep_cnt_nxt_s  = '0;
                    held_nxt_s     = 1'b0;
                end else if (state_r) begin
                    if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                        if (hold_cnt_r == HOLD_LAST) begin
                            long_nxt_s    = 1'b1;
                            held_nxt_s    = 1'b1;
                            rep_cnt_nxt_s = '0;
                        end else begin
                            long_nxt_s = 1'b0;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rep_cnt_r == REP_LAST) begin
                            repeat_nxt_s  = 1'b1;
                            rep_cnt_nxt_s = '0;
                        end else begin
                            rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
                        end
                    end else begin
                        rep_cnt_nxt_s = '0;
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end else begin
                stab_cnt_nxt_s = stab_cnt_r;
            end
        end

        // Per-channel state and registered pulse outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stab_cnt_r <= '0;
                hold_cnt_r <= '0;
                rep_cnt_r  <= '0;
                state_r    <= 1'b0;
                held_r     <= 1'b0;
                rise_r     <= 1'b0;
                fall_r     <= 1'b0;
                long_r     <= 1'b0;
                repeat_r   <= 1'b0;
            end else begin
                stab_cnt_r <= stab_cnt_nxt_s;
                hold_cnt_r <= hold_cnt_nxt_s;
                rep_cnt_r  <= rep_cnt_nxt_s;
                state_r    <= state_nxt_s;
                held_r     <= held_nxt_s;
                rise_r     <= rise_nxt_s;
                fall_r     <= fall_nxt_s;
                long_r     <= long_nxt_s;
                repeat_r   <= repeat_nxt_s;
            end
        end

        assign rise_s[g]     = rise_nxt_s;
        assign btn_state[g]  = state_r;
        assign btn_held[g]   = held_r;
        assign btn_rise[g]   = rise_r;
        assign btn_fall[g]   = fall_r;
        assign btn_long[g]   = long_r;
        assign btn_repeat[g] = repeat_r;
    end

    // Aggregate press flag, registered alongside the per-channel rise pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_rise_r <= 1'b0;
        end else begin
            any_rise_r <= |rise_s;
        end
    end

    assign any_rise = any_rise_r;

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Directed bench for button_debouncer_multi: expected pulse events are queued
// with their tick index when stimulus is applied and matched against a monitor.
module tb_button_debouncer_multi;

    logic       clk, rst_n, tick_1khz;
    logic [3:0] a_in, a_state, a_rise, a_fall, a_long, a_rep, a_held;
    logic [3:0] b_in, b_state, b_rise, b_fall, b_long, b_rep, b_held;
    logic       a_any, b_any;

    int   cmp = 0;
    int   mism = 0;
    int   tick_num = 0;
    int   div = 0;
    logic edge_was_tick = 1'b0;
    int   exp_q[$];
    int   obs_q[$];
    int   t0, r0, u0;

    button_debouncer_multi #(.NUM_CH(4), .STABLE_COUNT(5), .LONG_COUNT(20), .REPEAT_COUNT(4),
                             .REPEAT_EN(1), .ACTIVE_LOW(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz), .btn_in(a_in),
        .btn_state(a_state), .btn_rise(a_rise), .btn_fall(a_fall), .btn_long(a_long),
        .btn_repeat(a_rep), .btn_held(a_held), .any_rise(a_any));

    button_debouncer_multi #(.NUM_CH(4), .STABLE_COUNT(5), .LONG_COUNT(20), .REPEAT_COUNT(4),
                             .REPEAT_EN(1), .ACTIVE_LOW(1), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz), .btn_in(b_in),
        .btn_state(b_state), .btn_rise(b_rise), .btn_fall(b_fall), .btn_long(b_long),
        .btn_repeat(b_rep), .btn_held(b_held), .any_rise(b_any));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock tick every 10 clocks, changed on the falling edge.
    initial begin
        tick_1khz = 1'b0;
        forever begin
            @(negedge clk);
            div = (div == 9) ? 0 : div + 1;
            tick_1khz = (div == 9);
        end
    end

    always @(posedge clk) begin
        edge_was_tick <= tick_1khz;
        if (tick_1khz) tick_num <= tick_num + 1;
    end

    function automatic int ev(input int t, input int d, input int k, input int c);
        return ((t * 2 + d) * 8 + k) * 8 + c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmp++;
        assert (obs === expv) else begin
            mism++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic record(input int d, input logic [3:0] r, input logic [3:0] f,
                          input logic [3:0] l, input logic [3:0] p, input logic any);
        logic [3:0] v;
        if ((r | f | l | p) != 4'b0000 || any) begin
            chk("pulse_on_tick", {31'b0, edge_was_tick}, 32'd1);
            chk("any_rise_eq_or", {31'b0, any}, {31'b0, |r});
        end
        for (int k = 0; k < 4; k++) begin
            v = (k == 0) ? r : (k == 1) ? f : (k == 2) ? l : p;
            for (int c = 0; c < 4; c++) begin
                if (v[c]) obs_q.push_back(ev(tick_num, d, k, c));
            end
        end
        if (any) obs_q.push_back(ev(tick_num, d, 4, 0));
    endtask

    // Event monitor: outputs of the preceding rising edge, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            record(0, a_rise, a_fall, a_long, a_rep, a_any);
            record(1, b_rise, b_fall, b_long, b_rep, b_any);
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick_1khz !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic check_events(input string tag);
        int n, o, e;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            chk(tag, o, e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_state"}, a_state, 0);
        chk({tag, "_a_rise"}, a_rise, 0);
        chk({tag, "_a_fall"}, a_fall, 0);
        chk({tag, "_a_long"}, a_long, 0);
        chk({tag, "_a_rep"}, a_rep, 0);
        chk({tag, "_a_held"}, a_held, 0);
        chk({tag, "_a_any"}, a_any, 0);
        chk({tag, "_b_state"}, b_state, 0);
        chk({tag, "_b_held"}, b_held, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in  = 4'b0000;
        b_in  = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #1 rst_n = 1'b1;

        // 1: clean press on ch0, accepted on the 6th tick, then released.
        wait_ticks(2);
        t0 = tick_num;
        a_in[0] = 1'b1;
        exp_q.push_back(ev(t0 + 6, 0, 0, 0));
        exp_q.push_back(ev(t0 + 6, 0, 4, 0));
        wait_ticks(5);
        chk("t1_state_tick5", a_state, 4'b0000);
        wait_ticks(1);
        chk("t1_state_tick6", a_state, 4'b0001);
        chk("t1_rise", a_rise, 4'b0001);
        chk("t1_any", a_any, 1);
        a_in[0] = 1'b0;
        exp_q.push_back(ev(t0 + 12, 0, 1, 0));
        wait_ticks(6);
        chk("t1_state_released", a_state, 4'b0000);
        check_events("t1_events");

        // 2: ch1 bounces every 3 ticks for 30 ticks, never accepted.
        wait_ticks(1);
        for (int i = 0; i < 10; i++) begin
            a_in[1] = (i % 2 == 0);
            wait_ticks(3);
            chk("t2_state", a_state, 4'b0000);
        end
        a_in[1] = 1'b0;
        wait_ticks(8);
        chk("t2_state_settled", a_state, 4'b0000);
        check_events("t2_events");

        // 3: ch2 long press with auto-repeat, released before a sixth repeat.
        wait_ticks(1);
        a_in[2] = 1'b1;
        wait_ticks(6);
        r0 = tick_num;
        chk("t3_state", a_state, 4'b0100);
        exp_q.push_back(ev(r0, 0, 0, 2));
        exp_q.push_back(ev(r0, 0, 4, 0));
        exp_q.push_back(ev(r0 + 20, 0, 2, 2));
        for (int k = 24; k <= 40; k += 4) exp_q.push_back(ev(r0 + k, 0, 3, 2));
        exp_q.push_back(ev(r0 + 42, 0, 1, 2));
        wait_ticks(19);
        chk("t3_held_tick19", a_held, 4'b0000);
        wait_ticks(1);
        chk("t3_held_tick20", a_held, 4'b0100);
        chk("t3_long_tick20", a_long, 4'b0100);
        wait_ticks(16);
        a_in[2] = 1'b0;
        wait_ticks(5);
        chk("t3_held_before_fall", a_held, 4'b0100);
        wait_ticks(1);
        chk("t3_held_after_fall", a_held, 4'b0000);
        chk("t3_state_after_fall", a_state, 4'b0000);
        wait_ticks(5);
        check_events("t3_events");

        // 4: ch3 fall accepted on hold tick 20 suppresses the long press.
        wait_ticks(1);
        a_in[3] = 1'b1;
        wait_ticks(6);
        r0 = tick_num;
        exp_q.push_back(ev(r0, 0, 0, 3));
        exp_q.push_back(ev(r0, 0, 4, 0));
        exp_q.push_back(ev(r0 + 20, 0, 1, 3));
        wait_ticks(14);
        a_in[3] = 1'b0;
        wait_ticks(6);
        chk("t4_state", a_state, 4'b0000);
        chk("t4_long", a_long, 4'b0000);
        chk("t4_held", a_held, 4'b0000);
        wait_ticks(3);
        check_events("t4_events");

        // 5: active-low instance, ch1 and ch3 pressed together.
        wait_ticks(1);
        t0 = tick_num;
        b_in = 4'b0101;
        exp_q.push_back(ev(t0 + 6, 1, 0, 1));
        exp_q.push_back(ev(t0 + 6, 1, 0, 3));
        exp_q.push_back(ev(t0 + 6, 1, 4, 0));
        wait_ticks(6);
        chk("t5_b_state", b_state, 4'b1010);
        chk("t5_b_rise", b_rise, 4'b1010);
        b_in = 4'b1111;
        exp_q.push_back(ev(t0 + 12, 1, 1, 1));
        exp_q.push_back(ev(t0 + 12, 1, 1, 3));
        wait_ticks(6);
        chk("t5_b_state_released", b_state, 4'b0000);
        check_events("t5_events");

        // 6: asynchronous reset with ch0 pressed, stab_cnt=3, hold_cnt=10.
        wait_ticks(1);
        a_in[0] = 1'b1;
        wait_ticks(6);
        r0 = tick_num;
        exp_q.push_back(ev(r0, 0, 0, 0));
        exp_q.push_back(ev(r0, 0, 4, 0));
        wait_ticks(7);
        a_in[0] = 1'b0;
        wait_ticks(3);
        chk("t6_state_pre_reset", a_state, 4'b0001);
        a_in[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        check_events("t6_pre_events");
        wait_ticks(1);
        u0 = tick_num;
        rst_n = 1'b1;
        exp_q.push_back(ev(u0 + 6, 0, 0, 0));
        exp_q.push_back(ev(u0 + 6, 0, 4, 0));
        wait_ticks(5);
        chk("t6_state_tick5", a_state, 4'b0000);
        wait_ticks(1);
        chk("t6_state_tick6", a_state, 4'b0001);
        chk("t6_rise_tick6", a_rise, 4'b0001);
        check_events("t6_events");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
